dual_pipe_arbiter: RTL and testbench

- Shares one downstream consumer between two 32-bit pipeline output streams.
- Each source is buffered in a small FIFO. Idle/bubble words, whose low TAG_W bits equal IDLE_TAG, are filtered out and counted.
- Valid words are merged round-robin into one registered output with a valid/ready handshake.
- Sits between the two pipelines and the consumer FSM, replacing direct fan-in of the pipeline outputs.

---
 rtl/arb_pkg.sv | 12 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/dual_pipe_arbiter.sv | 118 +++++++++++
 tb/tb_dual_pipe_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and the bubble-detect helper for the dual pipeline arbiter.
package arb_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam logic [TAG_W-1:0] IDLE_TAG = 5'h1f;

    function automatic logic is_bubble(input logic [DATA_W-1:0] word);
        return (word[TAG_W-1:0] == IDLE_TAG);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; full/empty come from an occupancy count so pointers
// can wrap freely modulo DEPTH.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == OCC_W'(DEPTH));
    assign empty = (count_q == OCC_W'(0));
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/dual_pipe_arbiter.sv
// Merges two pipeline output streams into one registered valid/ready stream,
// dropping and counting idle/bubble words on the way in.
module dual_pipe_arbiter
    import arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data0,
    input  logic              in_valid0,
    output logic              in_ready0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic              in_valid1,
    output logic              in_ready1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  bubble_cnt0,
    output logic [CNT_W-1:0]  bubble_cnt1
);
    logic              full0, full1, empty0, empty1;
    logic [DATA_W-1:0] head0, head1;
    logic              push0, push1, pop0, pop1;
    logic              bub0, bub1, load, grant;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;
    logic              out_valid_q, out_valid_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk(clk), .reset(reset), .push(push0), .pop(pop0), .push_data(in_data0),
        .full(full0), .empty(empty0), .head(head0)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .push(push1), .pop(pop1), .push_data(in_data1),
        .full(full1), .empty(empty1), .head(head1)
    );

    // Ready comes only from FIFO state, so a full FIFO refuses even while popping.
    assign in_ready0 = !full0;
    assign in_ready1 = !full1;

    always_comb begin
        bub0   = in_valid0 && !full0 && is_bubble(in_data0);
        bub1   = in_valid1 && !full1 && is_bubble(in_data1);
        push0  = in_valid0 && !full0 && !is_bubble(in_data0);
        push1  = in_valid1 && !full1 && !is_bubble(in_data1);
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (bub0 && (cnt0_q != {CNT_W{1'b1}})) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (bub1 && (cnt1_q != {CNT_W{1'b1}})) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        pop0         = 1'b0;
        pop1         = 1'b0;
        load         = (!out_valid_q || out_ready) && (!empty0 || !empty1);
        // On a tie the source that did not win last time gets the slot.
        if (empty0) begin
            grant = 1'b1;
        end else if (empty1) begin
            grant = 1'b0;
        end else begin
            grant = !last_grant_q;
        end
        if (load) begin
            out_data_d   = grant ? head1 : head0;
            out_src_d    = grant;
            out_valid_d  = 1'b1;
            last_grant_d = grant;
            pop0         = !grant;
            pop1         = grant;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_src     = out_src_q;
    assign out_valid   = out_valid_q;
    assign bubble_cnt0 = cnt0_q;
    assign bubble_cnt1 = cnt1_q;

endmodule

// File: tb/tb_dual_pipe_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_dual_pipe_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data0 = 32'h0, in_data1 = 32'h0;
    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic        in_ready0, in_ready1;
    logic [31:0] out_data;
    logic        out_src, out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] bubble_cnt0, bubble_cnt1;

    int checks = 0;
    int failures = 0;

    dual_pipe_arbiter dut (
        .clk(clk), .reset(reset),
        .in_data0(in_data0), .in_valid0(in_valid0), .in_ready0(in_ready0),
        .in_data1(in_data1), .in_valid1(in_valid1), .in_ready1(in_ready1),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready),
        .bubble_cnt0(bubble_cnt0), .bubble_cnt1(bubble_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO contents as queues, output slot as plain variables.
    logic [31:0] m0[$], m1[$];
    logic        m_ov, m_os, m_last;
    logic [31:0] m_od;
    logic [15:0] m_c0, m_c1;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        bit r0, r1, ld;
        int g;
        if (reset) begin
            m0.delete(); m1.delete();
            m_ov = 1'b0; m_os = 1'b0; m_od = 32'h0; m_last = 1'b1;
            m_c0 = 16'h0; m_c1 = 16'h0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            r0 = (m0.size() < DEPTH);
            r1 = (m1.size() < DEPTH);
            ld = (!m_ov || out_ready) && (m0.size() > 0 || m1.size() > 0);
            if (ld) begin
                if (m0.size() == 0) g = 1;
                else if (m1.size() == 0) g = 0;
                else g = (m_last == 1'b1) ? 0 : 1;
                m_od = (g == 0) ? m0.pop_front() : m1.pop_front();
                m_os = (g == 1);
                m_last = (g == 1);
                m_ov = 1'b1;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (in_valid0 && r0) begin
                if (in_data0[4:0] == 5'h1f) begin
                    if (m_c0 != 16'hffff) m_c0 = m_c0 + 16'd1;
                end else m0.push_back(in_data0);
            end
            if (in_valid1 && r1) begin
                if (in_data1[4:0] == 5'h1f) begin
                    if (m_c1 != 16'hffff) m_c1 = m_c1 + 16'd1;
                end else m1.push_back(in_data1);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_out_valid", {63'h0, out_valid}, {63'h0, m_ov});
            chk("m_out_data", {32'h0, out_data}, {32'h0, m_od});
            chk("m_out_src", {63'h0, out_src}, {63'h0, m_os});
            chk("m_in_ready0", {63'h0, in_ready0}, {63'h0, (m0.size() < DEPTH)});
            chk("m_in_ready1", {63'h0, in_ready1}, {63'h0, (m1.size() < DEPTH)});
            chk("m_bubble_cnt0", {48'h0, bubble_cnt0}, {48'h0, m_c0});
            chk("m_bubble_cnt1", {48'h0, bubble_cnt1}, {48'h0, m_c1});
        end
    end

    // Record words actually handed to the consumer.
    logic [31:0] got_d[$];
    logic        got_s[$];
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_s.push_back(out_src);
        end
    end

    logic [31:0] s0[$], s1[$];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic feed(input int budget);
        int  n = 0;
        bit  a0, a1;
        while ((s0.size() > 0 || s1.size() > 0) && n < budget) begin
            in_valid0 = (s0.size() > 0);
            in_valid1 = (s1.size() > 0);
            if (in_valid0) in_data0 = s0[0];
            if (in_valid1) in_data1 = s1[0];
            a0 = in_valid0 && in_ready0;
            a1 = in_valid1 && in_ready1;
            tick();
            n++;
            if (a0) void'(s0.pop_front());
            if (a1) void'(s1.pop_front());
        end
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        chk("feed_done", 64'(s0.size() + s1.size()), 64'd0);
    endtask

    logic [31:0] exp_rr[6] = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
    logic        exp_rs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then idle.
        do_reset();
        idle(2);
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_in_ready0", {63'h0, in_ready0}, 64'd1);
        chk("rst_in_ready1", {63'h0, in_ready1}, 64'd1);
        chk("rst_cnt0", {48'h0, bubble_cnt0}, 64'd0);
        chk("rst_cnt1", {48'h0, bubble_cnt1}, 64'd0);
        chk("rst_out_data", {32'h0, out_data}, 64'd0);

        // Single word: two-cycle latency, then valid drops.
        out_ready = 1'b1;
        in_valid0 = 1'b1;
        in_data0  = 32'h0000_0120;
        tick();
        in_valid0 = 1'b0;
        chk("lat_t1_valid", {63'h0, out_valid}, 64'd0);
        tick();
        chk("lat_t2_valid", {63'h0, out_valid}, 64'd1);
        chk("lat_t2_data", {32'h0, out_data}, 64'h120);
        chk("lat_t2_src", {63'h0, out_src}, 64'd0);
        tick();
        chk("lat_t3_valid", {63'h0, out_valid}, 64'd0);
        chk("lat_t3_hold", {32'h0, out_data}, 64'h120);

        // Round robin under contention.
        do_reset();
        got_d.delete(); got_s.delete();
        out_ready = 1'b1;
        s0 = '{32'hA0, 32'hA1, 32'hA2};
        s1 = '{32'hB0, 32'hB1, 32'hB2};
        feed(40);
        idle(6);
        chk("rr_count", 64'(got_d.size()), 64'd6);
        for (int i = 0; i < 6 && i < got_d.size(); i++) begin
            chk($sformatf("rr_word%0d", i), {32'h0, got_d[i]}, {32'h0, exp_rr[i]});
            chk($sformatf("rr_src%0d", i), {63'h0, got_s[i]}, {63'h0, exp_rs[i]});
        end

        // Bubble filtering on source 1.
        do_reset();
        got_d.delete(); got_s.delete();
        s1 = '{32'hDEAD_BE1F, 32'hDEAD_BE1F, 32'hDEAD_BE1F, 32'hDEAD_BE1F, 32'h0000_0001};
        feed(40);
        idle(6);
        chk("bub_cnt1", {48'h0, bubble_cnt1}, 64'd4);
        chk("bub_cnt0", {48'h0, bubble_cnt0}, 64'd0);
        chk("bub_count", 64'(got_d.size()), 64'd1);
        if (got_d.size() > 0) begin
            chk("bub_word", {32'h0, got_d[0]}, 64'h1);
            chk("bub_src", {63'h0, got_s[0]}, 64'd1);
        end

        // Backpressure: two in the FIFO plus one held at the output.
        do_reset();
        got_d.delete(); got_s.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid0 = 1'b1;
            in_data0  = 32'hC0 + 32'(i);
            tick();
        end
        chk("bp_ready0", {63'h0, in_ready0}, 64'd0);
        chk("bp_valid", {63'h0, out_valid}, 64'd1);
        chk("bp_data", {32'h0, out_data}, 64'hC0);
        in_data0 = 32'hC3;
        tick();
        tick();
        chk("bp_ready0_hold", {63'h0, in_ready0}, 64'd0);
        chk("bp_data_stable", {32'h0, out_data}, 64'hC0);
        in_valid0 = 1'b0;
        s0 = '{32'hC3};
        out_ready = 1'b1;
        feed(20);
        idle(6);
        chk("bp_count", 64'(got_d.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            chk($sformatf("bp_word%0d", i), {32'h0, got_d[i]}, 64'hC0 + 64'(i));
        end

        // Reset with both FIFOs full and a word waiting at the output.
        do_reset();
        out_ready = 1'b0;
        s0 = '{32'h100, 32'h101, 32'h102};
        s1 = '{32'h21F, 32'h200, 32'h201};
        feed(20);
        chk("mid_full0", {63'h0, in_ready0}, 64'd0);
        chk("mid_full1", {63'h0, in_ready1}, 64'd0);
        chk("mid_cnt1", {48'h0, bubble_cnt1}, 64'd1);
        chk("mid_valid", {63'h0, out_valid}, 64'd1);
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", {63'h0, out_valid}, 64'd0);
        chk("mid_rst_ready0", {63'h0, in_ready0}, 64'd1);
        chk("mid_rst_ready1", {63'h0, in_ready1}, 64'd1);
        chk("mid_rst_cnt1", {48'h0, bubble_cnt1}, 64'd0);
        got_d.delete(); got_s.delete();
        idle(6);
        chk("mid_no_stale", 64'(got_d.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
